// File: rtl/param_counter_if.sv
// param_counter_if: control/status bundle between a controller and param_counter.
//   en, up, mode, presc, limit, load, load_val : controller -> counter
//   q, tc, done                                : counter -> consumers
interface param_counter_if #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PRESC_W = 24
);
   logic               en;
   logic               up;
   logic [1:0]         mode;
   logic [PRESC_W-1:0] presc;
   logic [WIDTH-1:0]   limit;
   logic               load;
   logic [WIDTH-1:0]   load_val;
   logic [WIDTH-1:0]   q;
   logic               tc;
   logic               done;

   modport master (
      output en, up, mode, presc, limit, load, load_val,
      input  q, tc, done
   );

   modport slave (
      input  en, up, mode, presc, limit, load, load_val,
      output q, tc, done
   );
endinterface

// File: rtl/param_counter.sv
// param_counter: WIDTH-bit up/down counter with programmable prescaler,
// runtime upper limit, synchronous clamped load and wrap/saturate/one-shot modes.
//   hw_clk : board clock
//   rst    : asynchronous active-low reset
//   bus    : param_counter_if.slave (controls in; q, tc, done out, all registered)
module param_counter #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned PRESC_W = 24
) (
   input  logic            hw_clk,
   input  logic            rst,
   param_counter_if.slave  bus
);

   localparam logic [1:0] MODE_WRAP    = 2'b00;
   localparam logic [1:0] MODE_SAT     = 2'b01;
   localparam logic [1:0] MODE_ONESHOT = 2'b10;

   logic [PRESC_W-1:0] pcnt, pcnt_nxt;
   logic [WIDTH-1:0]   q, q_nxt;
   logic               tc, tc_nxt;
   logic               done, done_nxt;

   logic               tick_c;
   logic               at_bound_c;
   logic [WIDTH-1:0]   bound_c;
   logic [WIDTH-1:0]   stepped_c;
   logic [WIDTH-1:0]   clamped_c;

   // >= rather than == so a presc lowered below pcnt still ticks immediately
   assign tick_c = bus.en & (pcnt >= bus.presc);

   // Step helpers; q above limit counts as at the upper bound
   always_comb begin
      bound_c    = bus.up ? bus.limit : '0;
      at_bound_c = bus.up ? (q >= bus.limit) : (q == '0);
      stepped_c  = bus.up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
      clamped_c  = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
   end

   // Next-state: load > tick > hold; tc defaults low so it is a single-cycle pulse
   always_comb begin
      pcnt_nxt = pcnt;
      q_nxt    = q;
      tc_nxt   = 1'b0;
      done_nxt = done;

      if (bus.load) begin
         pcnt_nxt = '0;
         q_nxt    = clamped_c;
         done_nxt = 1'b0;
      end else if (tick_c) begin
         pcnt_nxt = '0;
         if ((bus.mode == MODE_ONESHOT) && done) begin
            // finished one-shot ignores ticks until reloaded
            q_nxt = q;
         end else if (!at_bound_c) begin
            q_nxt  = stepped_c;
            tc_nxt = (bus.mode == MODE_SAT) && (stepped_c == bound_c);
         end else begin
            case (bus.mode)
               MODE_SAT: begin
                  q_nxt = q;
               end
               MODE_ONESHOT: begin
                  tc_nxt   = 1'b1;
                  done_nxt = 1'b1;
               end
               default: begin
                  // MODE_WRAP and the reserved encoding both wrap
                  q_nxt  = bus.up ? '0 : bus.limit;
                  tc_nxt = 1'b1;
               end
            endcase
         end
      end else if (bus.en) begin
         pcnt_nxt = pcnt + PRESC_W'(1);
      end
   end

   // State registers
   always_ff @(posedge hw_clk or negedge rst) begin
      if (!rst) begin
         pcnt <= '0;
         q    <= '0;
         tc   <= 1'b0;
         done <= 1'b0;
      end else begin
         pcnt <= pcnt_nxt;
         q    <= q_nxt;
         tc   <= tc_nxt;
         done <= done_nxt;
      end
   end

   assign bus.q    = q;
   assign bus.tc   = tc;
   assign bus.done = done;

endmodule

// File: tb/tb_param_counter.sv
// tb_param_counter: directed + randomized bench for param_counter with a
// cycle-level behavioural model of counting, prescaling, loading and modes.
module tb_param_counter;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned PRESC_W = 8;

   logic hw_clk;
   logic rst;
   int   checks;
   int   errors;

   // reference model state
   int   m_q;
   int   m_pcnt;
   bit   m_tc;
   bit   m_done;

   param_counter_if #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) bus ();

   param_counter #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .hw_clk (hw_clk),
      .rst    (rst),
      .bus    (bus)
   );

   initial hw_clk = 1'b0;
   always #5 hw_clk = ~hw_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q    = 0;
      m_pcnt = 0;
      m_tc   = 0;
      m_done = 0;
   endtask

   // One rising edge of the counter as described by its rules
   task automatic model_edge();
      int lim;
      int lv;
      int mode;
      lim  = int'(bus.limit);
      lv   = int'(bus.load_val);
      mode = int'(bus.mode);
      if (bus.load) begin
         m_q    = (lv < lim) ? lv : lim;
         m_pcnt = 0;
         m_done = 0;
         m_tc   = 0;
      end else if (bus.en && m_pcnt >= int'(bus.presc)) begin
         m_pcnt = 0;
         m_tc   = 0;
         if (mode == 2 && m_done) begin
            // ignored
         end else if (bus.up) begin
            if (m_q < lim) begin
               m_q = m_q + 1;
               if (mode == 1 && m_q == lim) m_tc = 1;
            end else if (mode == 1) begin
               // hold
            end else if (mode == 2) begin
               m_tc   = 1;
               m_done = 1;
            end else begin
               m_q  = 0;
               m_tc = 1;
            end
         end else begin
            if (m_q > 0) begin
               m_q = m_q - 1;
               if (mode == 1 && m_q == 0) m_tc = 1;
            end else if (mode == 1) begin
               // hold
            end else if (mode == 2) begin
               m_tc   = 1;
               m_done = 1;
            end else begin
               m_q  = lim;
               m_tc = 1;
            end
         end
      end else begin
         if (bus.en) m_pcnt = m_pcnt + 1;
         m_tc = 0;
      end
   endtask

   task automatic cyc();
      @(posedge hw_clk);
      model_edge();
      #1;
      check("q", 32'(bus.q), 32'(m_q));
      check("tc", 32'(bus.tc), 32'(m_tc));
      check("done", 32'(bus.done), 32'(m_done));
   endtask

   task automatic do_load(input int val);
      bus.load_val = WIDTH'(val);
      bus.load     = 1'b1;
      cyc();
      bus.load     = 1'b0;
   endtask

   initial begin
      int tc_cnt;
      checks = 0;
      errors = 0;
      model_reset();
      rst          = 1'b0;
      bus.en       = 1'b0;
      bus.up       = 1'b1;
      bus.mode     = 2'b00;
      bus.presc    = '0;
      bus.limit    = 8'd255;
      bus.load     = 1'b0;
      bus.load_val = '0;

      // reset state
      #50;
      check("rst_q", 32'(bus.q), 32'd0);
      check("rst_tc", 32'(bus.tc), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      #50;
      rst = 1'b1;

      // free-running wrap over the full range
      bus.en = 1'b1;
      for (int k = 1; k <= 520; k++) begin
         cyc();
         if (k == 256 || k == 512) begin
            check("wrap_tc_edge", 32'(bus.tc), 32'd1);
            check("wrap_q_edge", 32'(bus.q), 32'd0);
         end
         if (k == 255) check("wrap_q255", 32'(bus.q), 32'd255);
      end

      // prescaled wrap with a freeze in the middle
      bus.presc = 8'd3;
      bus.limit = 8'd5;
      do_load(0);
      for (int k = 0; k < 30; k++) cyc();
      bus.en = 1'b0;
      for (int k = 0; k < 6; k++) cyc();
      bus.en = 1'b1;
      for (int k = 0; k < 24; k++) cyc();

      // down count into saturation
      bus.presc = '0;
      bus.limit = 8'd255;
      bus.up    = 1'b0;
      bus.mode  = 2'b01;
      do_load(3);
      tc_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         cyc();
         if (bus.tc) tc_cnt++;
      end
      check("sat_tc_count", 32'(tc_cnt), 32'd1);
      check("sat_q_hold", 32'(bus.q), 32'd0);

      // one-shot up to 4, then reload
      bus.limit = 8'd4;
      bus.up    = 1'b1;
      bus.mode  = 2'b10;
      do_load(0);
      for (int k = 0; k < 8; k++) cyc();
      check("os_done", 32'(bus.done), 32'd1);
      check("os_q", 32'(bus.q), 32'd4);
      do_load(2);
      check("os_reload_done", 32'(bus.done), 32'd0);
      check("os_reload_q", 32'(bus.q), 32'd2);
      for (int k = 0; k < 6; k++) cyc();

      // load clamps to limit and beats a simultaneous tick
      bus.mode  = 2'b00;
      bus.presc = 8'd2;
      bus.limit = 8'd50;
      do_load(10);
      for (int k = 0; k < 20 && m_pcnt < 2; k++) cyc();
      do_load(200);
      check("ld_clamp_q", 32'(bus.q), 32'd50);
      check("ld_clamp_tc", 32'(bus.tc), 32'd0);
      for (int k = 0; k < 8; k++) cyc();

      // randomized operation
      for (int k = 0; k < 2500; k++) begin
         bus.en   = ($urandom_range(0, 9) != 0);
         bus.load = ($urandom_range(0, 29) == 0);
         bus.load_val = WIDTH'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) bus.up = ~bus.up;
         if ($urandom_range(0, 39) == 0) bus.mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) bus.presc = PRESC_W'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0)
            bus.limit = ($urandom_range(0, 3) == 0) ? WIDTH'(0) : WIDTH'($urandom_range(0, 12));
         cyc();
      end
      bus.load = 1'b0;

      // async reset between edges while tc is high
      bus.en    = 1'b1;
      bus.up    = 1'b1;
      bus.mode  = 2'b01;
      bus.presc = '0;
      bus.limit = 8'h37;
      do_load(8'h36);
      cyc();
      check("pre_rst_q", 32'(bus.q), 32'h37);
      check("pre_rst_tc", 32'(bus.tc), 32'd1);
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      check("async_q", 32'(bus.q), 32'd0);
      check("async_tc", 32'(bus.tc), 32'd0);
      check("async_done", 32'(bus.done), 32'd0);
      @(negedge hw_clk);
      rst = 1'b1;
      for (int k = 0; k < 5; k++) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/param_counter.md
# param_counter

Parametrised successor to the board-level 8-bit free-running counter. It is a WIDTH-bit up/down counter with:
- a programmable prescaler on the board clock;
- a runtime upper limit;
- synchronous load;
- three count modes: wrap, saturate and one-shot.

It sits between the board clock/reset and LED or PWM consumers, and exposes a terminal-count pulse for chaining.

## Interface
- WIDTH, 8, counter width in bits (legal 2..32)
- PRESC_W, 24, prescaler width in bits (legal 1..32)
- hw_clk  in  1  board clock (12 MHz on SQUADRON-FM)
- rst  in  1  asynchronous, active-low reset
- en  in  1  count enable; gates the prescaler and stepping
- up  in  1  direction: 1 = up, 0 = down
- mode  in  2  00 wrap, 01 saturate, 10 one-shot, 11 treated as wrap
- presc  in  PRESC_W  step period minus one, in hw_clk cycles
- limit  in  WIDTH  upper bound; count range is 0..limit
- load  in  1  synchronous load strobe
- load_val  in  WIDTH  value loaded on load
- q  out  WIDTH  registered count
- tc  out  1  registered one-cycle terminal-count pulse
- done  out  1  one-shot finished flag, sticky

## Operation
- Reset (rst=0, asynchronous): q=0, tc=0, done=0, prescaler count=0. All outputs hold these values until the first hw_clk edge after rst=1.
- Prescaler: internal pcnt counts 0..presc while en=1.
  - tick = en & (pcnt==presc); pcnt returns to 0 on tick.
  - presc=0 gives a tick every cycle.
  - en=0 holds pcnt and q.
  - presc changed below the current pcnt: treat pcnt>=presc as tick.
- Priority per edge: load > tick > hold.
- Load: q <= min(load_val, limit); pcnt <= 0; done <= 0; tc <= 0. Load works regardless of en and done.
- Bound: limit when up=1 (q>=limit counts as at bound), 0 when up=0.
- Step on tick, q not at bound: q <= q±1 and tc <= 0, except in saturate mode where tc <= 1 if the new q equals the bound.
- Step on tick, q at bound:
  - wrap: q <= opposite end (0 going up, limit going down); tc <= 1.
  - saturate: q holds; tc <= 0.
  - one-shot: q holds; tc <= 1; done <= 1.
- One-shot with done=1: ticks are ignored; q, tc=0 and done hold until load or reset. The prescaler keeps running.
- Arithmetic is modulo 2^WIDTH internally but never leaves 0..limit after any load or step.
- limit changed at runtime below q: the next up tick treats q as at bound. In wrap mode q goes to 0; a down tick decrements normally.
- limit=0: q stays 0.
  - wrap: tc pulses every tick.
  - one-shot: first tick sets done.
- Mode or direction change takes effect on the next tick; no state is cleared.
- Reset mid-operation clears everything immediately, including a pending tc.

## Timing
- All state changes occur on hw_clk rising edge; no combinational input-to-output paths.
- q and tc update on the same edge; tc is high for exactly one cycle per qualifying tick.
- With en rising at edge 0 from pcnt=0, the first step occurs at edge presc+1, then every presc+1 cycles.
- Load: q shows the loaded value one cycle after the strobe is sampled; the next step follows presc+1 cycles later.
- done rises on the same edge as the final tc pulse.

## Test plan
- Reset/wrap: rst=0 for 100 ns, then 1; en=1, up=1, mode=00, presc=0, limit=255 → q counts 0..255; tc=1 only on the cycle q returns 0 at edge 256; repeats at edge 512.
- Prescale: presc=3, limit=5, up=1, mode=00 → q steps every 4 cycles 0,1,…,5,0; tc one-cycle high with the 5→0 step; en=0 mid-count freezes q and pcnt.
- Down/saturate: load_val=3, up=0, mode=01, presc=0 → q 3,2,1,0 then holds 0; tc single pulse on the 1→0 edge; no further tc.
- One-shot: limit=4, load 0, up=1, mode=10 → q 1,2,3,4; on the next tick tc=1 and done=1; q stays 4; a later load of 2 clears done and restarts from 2.
- Load priority/clamp: load with load_val=200, limit=50 asserted on the same edge as a tick → q=50, no step, tc=0, pcnt=0.
- Async reset mid-count: q=0x37, tc high; drive rst=0 between edges → q=0, tc=0, done=0 immediately, without waiting for a clock edge.
